// File: rtl/shift_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_accum_pkg
//  Description : Shared state encoding and default parameter values for the
//                shift-and-accumulate block.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_accum_pkg;

    localparam int c_in_w      = 8;
    localparam int c_step      = 4;
    localparam int c_out_w     = 32;
    localparam int c_num_sel   = 7;
    localparam int c_num_terms = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_accum_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_accum_if
//  Description : Term input, result output and status bundle of
//                shift_accum. The master drives terms and consumes results;
//                the slave is the accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_accum_if #(
    parameter int IN_W  = shift_accum_pkg::c_in_w,
    parameter int SEL_W = $clog2(shift_accum_pkg::c_num_sel + 1),
    parameter int OUT_W = shift_accum_pkg::c_out_w
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [SEL_W-1:0] in_sel;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             busy;
    logic             err;
    logic             ovf;

    modport master (
        output start, in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, busy, err, ovf
    );

    modport slave (
        input  start, in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, busy, err, ovf
    );
endinterface
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift_stage
//  Description : Combinational shifter placing a partial product at bit
//                position i_sel*STEP inside an OUT_W-bit word. Bits pushed
//                past OUT_W are dropped. Out-of-range selects yield zero and
//                raise o_illegal so no undefined value reaches the adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_stage #(
    parameter int IN_W    = shift_accum_pkg::c_in_w,
    parameter int STEP    = shift_accum_pkg::c_step,
    parameter int OUT_W   = shift_accum_pkg::c_out_w,
    parameter int NUM_SEL = shift_accum_pkg::c_num_sel,
    localparam int SEL_W  = $clog2(NUM_SEL + 1)
) (
    input  wire logic [IN_W-1:0]  i_data,
    input  wire logic [SEL_W-1:0] i_sel,
    output logic      [OUT_W-1:0] o_shifted,
    output logic                  o_illegal
);

    logic [31:0] w_amt;

    // Select decode and shift; an illegal select contributes nothing.
    always_comb begin
        o_illegal = (32'(i_sel) >= 32'(NUM_SEL));
        w_amt     = 32'(i_sel) * 32'(STEP);
        o_shifted = '0;
        if (!o_illegal) begin
            o_shifted = OUT_W'(i_data) << w_amt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_accum.sv
`default_nettype none
// ============================================================================
//  Module      : shift_accum
//  Description : Accumulates NUM_TERMS shifted partial products into an
//                OUT_W-bit result, flagging illegal selects (err) and carry
//                out of the accumulator (ovf). The result is held with
//                valid/ready backpressure until consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_accum
    import shift_accum_pkg::*;
#(
    parameter int IN_W      = c_in_w,
    parameter int STEP      = c_step,
    parameter int OUT_W     = c_out_w,
    parameter int NUM_SEL   = c_num_sel,
    parameter int NUM_TERMS = c_num_terms
) (
    input wire logic      clk,
    input wire logic      rst_n,
    shift_accum_if.slave  bus
);

    localparam int SEL_W   = $clog2(NUM_SEL + 1);
    localparam int c_cnt_w = $clog2(NUM_TERMS + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_TERMS - 1);

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q,   acc_d;
    logic [c_cnt_w-1:0] cnt_q,   cnt_d;
    logic               err_q,   err_d;
    logic               ovf_q,   ovf_d;

    logic [OUT_W-1:0]   w_shifted;
    logic               w_illegal;
    logic [OUT_W:0]     w_sum;

    shift_stage #(
        .IN_W    (IN_W),
        .STEP    (STEP),
        .OUT_W   (OUT_W),
        .NUM_SEL (NUM_SEL)
    ) u_shift_stage (
        .i_data    (bus.in_data),
        .i_sel     (bus.in_sel),
        .o_shifted (w_shifted),
        .o_illegal (w_illegal)
    );

    // One extra bit on the add captures the carry out of the accumulator.
    assign w_sum = {1'b0, acc_q} + {1'b0, w_shifted};

    // Next-state, accumulator, term counter and sticky flag update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (bus.start) begin
                    // Restart wins over a beat presented in the same cycle.
                    acc_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    ovf_d = 1'b0;
                end else if (bus.in_valid) begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                    if (w_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        acc_d = w_sum[OUT_W-1:0];
                        ovf_d = ovf_q | w_sum[OUT_W];
                    end
                    if (cnt_q == c_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (bus.start) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = acc_q;
    assign bus.err       = err_q;
    assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_accum
//  Description : Self-checking bench for shift_accum with an arithmetic
//                reference model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_accum;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_accum_if #(.IN_W(8), .SEL_W(3), .OUT_W(32)) bus ();

    shift_accum #(
        .IN_W(8), .STEP(4), .OUT_W(32), .NUM_SEL(7), .NUM_TERMS(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 collecting, 2 holding result.
    // m_sum is the exact sum of all (truncated) terms; its upper half being
    // nonzero means the 32-bit accumulator wrapped at least once.
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic        m_err   = 1'b0;
    logic [63:0] m_sum   = 64'd0;

    task automatic m_clear();
        m_sum = 64'd0;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_clear();
        end else begin
            case (m_phase)
                0: if (bus.start) begin m_phase = 1; m_clear(); end
                1: begin
                    if (bus.start) begin
                        m_clear();
                    end else if (bus.in_valid) begin
                        m_cnt++;
                        if (bus.in_sel >= 7) m_err = 1'b1;
                        else m_sum = m_sum + ((64'(bus.in_data) << (bus.in_sel * 4)) & 64'hFFFF_FFFF);
                        if (m_cnt == 4) m_phase = 2;
                    end
                end
                default: if (bus.out_ready) begin
                    if (bus.start) begin m_phase = 1; m_clear(); end
                    else m_phase = 0;
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("cycle{rdy,vld,busy,err,ovf,data}",
            {27'd0, bus.in_ready, bus.out_valid, bus.busy, bus.err, bus.ovf, bus.out_data},
            {27'd0, m_phase == 1, m_phase == 2, m_phase != 0, m_err, m_sum[63:32] != 32'd0, m_sum[31:0]});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_acc();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic [2:0] s);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = s;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic mult_beats();
        beat(8'h8F, 3'd0);
        beat(8'h82, 3'd1);
        beat(8'h84, 3'd1);
        beat(8'h78, 3'd2);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", {bus.in_ready, bus.out_valid, bus.busy, bus.err, bus.ovf, bus.out_data}, 64'd0);
        rst_n = 1'b1;

        // Beats while idle are ignored
        bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.in_sel = 3'd0;
        tick(); tick();
        bus.in_valid = 1'b0;
        chk("idle_ignore_data", bus.out_data, 64'd0);

        // 0xAB * 0xCD by nibble partial products
        start_acc();
        mult_beats();
        chk("mult_valid_next_cycle", bus.out_valid, 1);
        chk("mult_data", bus.out_data, 64'h88EF);
        chk("mult_err", bus.err, 0);
        chk("mult_ovf", bus.ovf, 0);

        // Backpressure
        repeat (5) begin
            tick();
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", bus.out_data, 64'h88EF);
        end
        release_result();
        chk("after_release_idle", {bus.out_valid, bus.busy}, 0);

        // Illegal select
        start_acc();
        beat(8'hFF, 3'd7);
        beat(8'h01, 3'd0);
        beat(8'h02, 3'd0);
        beat(8'h03, 3'd0);
        chk("illegal_data", bus.out_data, 64'h6);
        chk("illegal_err", bus.err, 1);
        release_result();

        // Overflow
        start_acc();
        repeat (4) beat(8'hFF, 3'd6);
        chk("ovf_data", bus.out_data, 64'hFC00_0000);
        chk("ovf_flag", bus.ovf, 1);

        // start in HOLD without out_ready is ignored
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("hold_start_ignored", {bus.out_valid, bus.out_data}, {31'd0, 1'b1, 32'hFC00_0000});

        // start with out_ready goes straight to a cleared ACCUM
        bus.start = 1'b1; bus.out_ready = 1'b1; tick();
        bus.start = 1'b0; bus.out_ready = 1'b0;
        chk("hold_restart", {bus.in_ready, bus.out_valid, bus.ovf, bus.out_data}, {29'd0, 3'b100, 32'd0});

        // Restart mid-accumulation, beat in the start cycle discarded
        beat(8'h11, 3'd0);
        beat(8'h22, 3'd1);
        chk("partial_sum", bus.out_data, 64'h231);
        bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.in_sel = 3'd2;
        tick();
        bus.start = 1'b0; bus.in_valid = 1'b0;
        chk("restart_cleared", {bus.busy, bus.out_data}, {31'd0, 1'b1, 32'd0});
        mult_beats();
        chk("restart_result", {bus.out_valid, bus.err, bus.out_data}, {30'd0, 2'b10, 32'h88EF});
        release_result();

        // Asynchronous reset mid-accumulation
        start_acc();
        beat(8'h8F, 3'd0);
        beat(8'h82, 3'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset", {bus.in_ready, bus.out_valid, bus.busy, bus.err, bus.ovf, bus.out_data}, 64'd0);
        tick();
        rst_n = 1'b1;
        beat(8'h12, 3'd0);
        beat(8'h12, 3'd1);
        chk("post_reset_ignore", {bus.in_ready, bus.out_data}, 64'd0);

        // Clean accumulation after reset, illegal last select
        start_acc();
        beat(8'h01, 3'd0);
        beat(8'h01, 3'd1);
        beat(8'h01, 3'd2);
        beat(8'h01, 3'd7);
        chk("post_reset_result", {bus.out_valid, bus.err, bus.out_data}, {30'd0, 2'b11, 32'h111});
        release_result();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
